// File: rtl/brc_pkg.sv
// brc_pkg: shared types and defaults for branch_redirect_ctrl.
//   state_e   : controller states (IDLE / FLUSH / LINK_WAIT)
//   CNT_W     : flush down-counter width (covers FLUSH_CYCLES up to 15)
//   STAT_W    : statistics counter width
package brc_pkg;
   localparam int ADDR_W_DEF   = 32;
   localparam int REG_IDX_DEF  = 4;
   localparam int LINK_REG_DEF = 14;
   localparam int CNT_W        = 4;
   localparam int STAT_W       = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLUSH     = 2'd1,
      LINK_WAIT = 2'd2
   } state_e;
endpackage

// File: rtl/brc_link_if.sv
// brc_link_if: link-register write channel towards the register file.
//   link_valid : write request (held until accepted)
//   link_ready : register file accepts the write
//   link_idx   : destination register index
//   link_data  : value to write (return address)
// modport master: controller side; modport slave: register-file side.
interface brc_link_if #(
   parameter int ADDR_W    = 32,
   parameter int REG_IDX_W = 4
);
   logic                 link_valid;
   logic                 link_ready;
   logic [REG_IDX_W-1:0] link_idx;
   logic [ADDR_W-1:0]    link_data;

   modport master (output link_valid, link_idx, link_data, input link_ready);
   modport slave  (input link_valid, link_idx, link_data, output link_ready);
endinterface

// File: rtl/brc_sat_counter.sv
// brc_sat_counter: W-bit counter that increments on inc, clears on clr and
// sticks at all-ones instead of wrapping.
//   clk, reset : clock, asynchronous active-high reset
//   inc, clr   : increment / synchronous clear (clear wins)
//   cnt_o      : current count
module brc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                       cnt_d = '0;
      else if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: applies taken-branch / branch-and-link decisions from
// EX to the front end: one-cycle PC redirect, FLUSH_CYCLES of IF/ID squash,
// and a valid/ready write of the return address into LINK_REG.
//   clk, reset            : clock, asynchronous active-high reset
//   t_address_i, bl_reg_i : branch taken / taken branch is BL
//   target_addr_i         : branch target; branch_pc_i : branch address
//   pc_sel_o, pc_target_o : PC mux select pulse and registered target
//   flush_o, stall_o      : squash IF/ID / freeze front end on pending link
//   busy_o                : controller not idle
//   link (master)         : link-register write channel
//   taken_cnt_o, bl_cnt_o, drop_cnt_o : statistics
// Optional feature macro BRANCH_STATS_EN: statistics counters present;
// otherwise the three statistic ports read 0.
module branch_redirect_ctrl
   import brc_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_IDX_W    = REG_IDX_DEF,
   parameter int LINK_REG     = LINK_REG_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              t_address_i,
   input  logic              bl_reg_i,
   input  logic [ADDR_W-1:0] target_addr_i,
   input  logic [ADDR_W-1:0] branch_pc_i,
   output logic              pc_sel_o,
   output logic [ADDR_W-1:0] pc_target_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic              busy_o,
   output logic [STAT_W-1:0] taken_cnt_o,
   output logic [STAT_W-1:0] bl_cnt_o,
   output logic [STAT_W-1:0] drop_cnt_o,
   brc_link_if.master        link
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pc_sel_q, pc_sel_d;
   logic [ADDR_W-1:0]  pc_target_q, pc_target_d;
   logic               link_valid_q, link_valid_d;
   logic [ADDR_W-1:0]  link_data_q, link_data_d;
   logic               xfer;
   logic               accept;

   assign accept = (state_q == IDLE) && t_address_i;
   assign xfer   = link_valid_q && link.link_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_sel_d     = 1'b0;
      pc_target_d  = pc_target_q;
      link_valid_d = link_valid_q;
      link_data_d  = link_data_q;
      if (xfer) link_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (t_address_i) begin
               state_d     = FLUSH;
               cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
               pc_sel_d    = 1'b1;
               pc_target_d = target_addr_i;
               if (bl_reg_i) begin
                  link_valid_d = 1'b1;
                  link_data_d  = branch_pc_i + ADDR_W'(4);
               end
            end
         end
         FLUSH: begin
            // The link may complete on the very edge the flush ends, in
            // which case there is nothing left to wait for.
            if (cnt_q == '0) state_d = (link_valid_q && !xfer) ? LINK_WAIT : IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         LINK_WAIT: if (xfer) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pc_sel_q     <= 1'b0;
         pc_target_q  <= '0;
         link_valid_q <= 1'b0;
         link_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc_sel_q     <= pc_sel_d;
         pc_target_q  <= pc_target_d;
         link_valid_q <= link_valid_d;
         link_data_q  <= link_data_d;
      end
   end

   assign pc_sel_o        = pc_sel_q;
   assign pc_target_o     = pc_target_q;
   assign flush_o         = (state_q == FLUSH);
   assign stall_o         = (state_q == LINK_WAIT);
   assign busy_o          = (state_q != IDLE);
   assign link.link_valid = link_valid_q;
   assign link.link_data  = link_data_q;
   assign link.link_idx   = REG_IDX_W'(LINK_REG);

`ifdef BRANCH_STATS_EN
   logic bl_accept, drop;
   assign bl_accept = accept && bl_reg_i;
   assign drop      = (state_q != IDLE) && t_address_i;

   brc_sat_counter #(.W(STAT_W)) u_taken_cnt (
      .clk(clk), .reset(reset), .inc(accept), .clr(1'b0), .cnt_o(taken_cnt_o));
   brc_sat_counter #(.W(STAT_W)) u_bl_cnt (
      .clk(clk), .reset(reset), .inc(bl_accept), .clr(1'b0), .cnt_o(bl_cnt_o));
   brc_sat_counter #(.W(STAT_W)) u_drop_cnt (
      .clk(clk), .reset(reset), .inc(drop), .clr(1'b0), .cnt_o(drop_cnt_o));
`else
   assign taken_cnt_o = '0;
   assign bl_cnt_o    = '0;
   assign drop_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
   localparam int F = 2;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        t_address_i, bl_reg_i;
   logic [31:0] target_addr_i, branch_pc_i;
   logic        pc_sel_o, flush_o, stall_o, busy_o;
   logic [31:0] pc_target_o;
   logic [15:0] taken_cnt_o, bl_cnt_o, drop_cnt_o;

   brc_link_if #(.ADDR_W(32), .REG_IDX_W(4)) link ();

   branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(F), .REG_IDX_W(4), .LINK_REG(14)) dut (
      .clk(clk), .reset(reset), .t_address_i(t_address_i), .bl_reg_i(bl_reg_i),
      .target_addr_i(target_addr_i), .branch_pc_i(branch_pc_i),
      .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o), .flush_o(flush_o),
      .stall_o(stall_o), .busy_o(busy_o), .taken_cnt_o(taken_cnt_o),
      .bl_cnt_o(bl_cnt_o), .drop_cnt_o(drop_cnt_o), .link(link));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: a branch occupies the front end for F flush cycles,
   // then for as long as its link write is still outstanding.
   int          m_flush_left;
   bit          m_waiting;
   bit          m_lv, m_psel;
   logic [31:0] m_ld, m_tgt;
   int          m_taken, m_bl, m_drop;

   task automatic model_reset();
      m_flush_left = 0; m_waiting = 0; m_lv = 0; m_psel = 0;
      m_ld = 0; m_tgt = 0; m_taken = 0; m_bl = 0; m_drop = 0;
   endtask

   // Advance model using current inputs, then take one clock edge.
   task automatic cyc();
      bit idle, xfer;
      idle = (m_flush_left == 0) && !m_waiting;
      xfer = m_lv && link.link_ready;
      m_psel = 0;
      if (!idle) begin
         if (t_address_i && m_drop < 65535) m_drop++;
         if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0 && m_lv && !xfer) m_waiting = 1;
         end else if (xfer) m_waiting = 0;
      end
      if (xfer) m_lv = 0;
      if (idle && t_address_i) begin
         m_psel = 1; m_tgt = target_addr_i; m_flush_left = F;
         if (m_taken < 65535) m_taken++;
         if (bl_reg_i) begin
            m_lv = 1; m_ld = branch_pc_i + 32'd4;
            if (m_bl < 65535) m_bl++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit t, input bit bl, input logic [31:0] tgt, input logic [31:0] pc);
      t_address_i = t; bl_reg_i = bl; target_addr_i = tgt; branch_pc_i = pc;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({pc_sel_o, flush_o, stall_o, busy_o, link.link_valid} !== 5'b0 || pc_target_o !== 0 || link.link_data !== 0) begin
         failures++; $display("FAIL reset_outputs got ctl=%b tgt=%h data=%h want 0", {pc_sel_o, flush_o, stall_o, busy_o, link.link_valid}, pc_target_o, link.link_data);
      end
      checks++;
      if (link.link_idx !== 4'd14 || taken_cnt_o !== 0 || bl_cnt_o !== 0 || drop_cnt_o !== 0) begin
         failures++; $display("FAIL reset_idx_cnt got idx=%0d t=%0d b=%0d d=%0d want 14,0,0,0", link.link_idx, taken_cnt_o, bl_cnt_o, drop_cnt_o);
      end
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_plain_b();
      drive(1, 0, 32'h100, 32'h80); cyc(); drive(0, 0, 0, 0);
      checks++;
      if (pc_sel_o !== 1 || pc_target_o !== 32'h100 || flush_o !== 1 || link.link_valid !== 0 || busy_o !== 1) begin
         failures++; $display("FAIL plain_b_c1 got sel=%b tgt=%h fl=%b lv=%b busy=%b want 1,100,1,0,1", pc_sel_o, pc_target_o, flush_o, link.link_valid, busy_o);
      end
      cyc();
      checks++;
      if (pc_sel_o !== 0 || flush_o !== 1 || busy_o !== 1) begin
         failures++; $display("FAIL plain_b_c2 got sel=%b fl=%b busy=%b want 0,1,1", pc_sel_o, flush_o, busy_o);
      end
      cyc();
      checks++;
      if (flush_o !== 0 || busy_o !== 0 || stall_o !== 0) begin
         failures++; $display("FAIL plain_b_c3 got fl=%b busy=%b st=%b want 0,0,0", flush_o, busy_o, stall_o);
      end
   endtask

   task automatic test_bl_ready();
      link.link_ready = 1;
      drive(1, 1, 32'h200, 32'h40); cyc(); drive(0, 0, 0, 0);
      checks++;
      if (link.link_valid !== 1 || link.link_data !== 32'h44 || link.link_idx !== 4'd14 || stall_o !== 0) begin
         failures++; $display("FAIL bl_ready_c1 got lv=%b data=%h idx=%0d st=%b want 1,44,14,0", link.link_valid, link.link_data, link.link_idx, stall_o);
      end
      cyc();
      checks++;
      if (link.link_valid !== 0 || stall_o !== 0 || flush_o !== 1) begin
         failures++; $display("FAIL bl_ready_c2 got lv=%b st=%b fl=%b want 0,0,1", link.link_valid, stall_o, flush_o);
      end
      cyc();
      checks++;
      if (busy_o !== 0 || stall_o !== 0) begin
         failures++; $display("FAIL bl_ready_c3 got busy=%b st=%b want 0,0", busy_o, stall_o);
      end
   endtask

   task automatic test_bl_wait();
      link.link_ready = 0;
      drive(1, 1, 32'h300, 32'h40); cyc(); drive(0, 0, 0, 0);
      cyc(); cyc();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (stall_o !== 1 || flush_o !== 0 || link.link_valid !== 1 || link.link_data !== 32'h44) begin
            failures++; $display("FAIL bl_wait_hold%0d got st=%b fl=%b lv=%b data=%h want 1,0,1,44", i, stall_o, flush_o, link.link_valid, link.link_data);
         end
         cyc();
      end
      link.link_ready = 1; cyc(); link.link_ready = 0;
      checks++;
      if (stall_o !== 0 || busy_o !== 0 || link.link_valid !== 0) begin
         failures++; $display("FAIL bl_wait_done got st=%b busy=%b lv=%b want 0,0,0", stall_o, busy_o, link.link_valid);
      end
   endtask

   task automatic test_drop();
      int d0;
      d0 = m_drop;
      link.link_ready = 0;
      drive(1, 1, 32'h400, 32'h10); cyc();
      drive(1, 0, 32'h999, 32'h20); cyc();   // during FLUSH
      drive(0, 0, 0, 0); cyc();
      drive(1, 1, 32'h888, 32'h30); cyc();   // during LINK_WAIT
      drive(0, 0, 0, 0);
      checks++;
      if (pc_sel_o !== 0 || pc_target_o !== 32'h400 || stall_o !== 1 || link.link_data !== 32'h14) begin
         failures++; $display("FAIL drop_ignored got sel=%b tgt=%h st=%b data=%h want 0,400,1,14", pc_sel_o, pc_target_o, stall_o, link.link_data);
      end
      link.link_ready = 1; cyc(); link.link_ready = 0;
      checks++;
      if (drop_cnt_o !== (STATS ? 16'(m_drop) : 16'd0) || (STATS && m_drop - d0 != 2)) begin
         failures++; $display("FAIL drop_count got %0d want %0d", drop_cnt_o, STATS ? m_drop : 0);
      end
   endtask

   task automatic test_wrap();
      link.link_ready = 1;
      drive(1, 1, 32'h500, 32'hFFFF_FFFC); cyc(); drive(0, 0, 0, 0);
      checks++;
      if (link.link_valid !== 1 || link.link_data !== 32'h0) begin
         failures++; $display("FAIL wrap got lv=%b data=%h want 1,00000000", link.link_valid, link.link_data);
      end
      cyc(); cyc();
   endtask

   task automatic test_reset_mid();
      link.link_ready = 0;
      drive(1, 1, 32'h600, 32'h70); cyc(); drive(0, 0, 0, 0);
      cyc(); cyc(); cyc();
      checks++;
      if (stall_o !== 1) begin
         failures++; $display("FAIL rst_mid_pre got st=%b want 1", stall_o);
      end
      #2 reset = 1; #1;
      checks++;
      if ({pc_sel_o, flush_o, stall_o, busy_o, link.link_valid} !== 5'b0 || pc_target_o !== 0 || link.link_data !== 0 || taken_cnt_o !== 0 || drop_cnt_o !== 0) begin
         failures++; $display("FAIL rst_mid_async got ctl=%b tgt=%h data=%h tc=%0d want all 0", {pc_sel_o, flush_o, stall_o, busy_o, link.link_valid}, pc_target_o, link.link_data, taken_cnt_o);
      end
      model_reset();
      @(posedge clk); #1; reset = 0;
      link.link_ready = 1; cyc(); cyc();
      checks++;
      if (link.link_valid !== 0 || busy_o !== 0 || bl_cnt_o !== 0) begin
         failures++; $display("FAIL rst_mid_after got lv=%b busy=%b bl=%0d want 0,0,0", link.link_valid, busy_o, bl_cnt_o);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 99) < 35), $urandom_range(0, 1), $urandom, $urandom);
         link.link_ready = ($urandom_range(0, 99) < 40);
         cyc();
         checks++;
         if ({pc_sel_o, flush_o, stall_o, busy_o, link.link_valid} !==
             {m_psel, m_flush_left > 0, m_waiting, (m_flush_left > 0) || m_waiting, m_lv}) begin
            failures++; $display("FAIL rand_ctl cyc %0d got sel/fl/st/busy/lv=%b want %b", n,
               {pc_sel_o, flush_o, stall_o, busy_o, link.link_valid},
               {m_psel, m_flush_left > 0, m_waiting, (m_flush_left > 0) || m_waiting, m_lv});
         end
         checks++;
         if (pc_target_o !== m_tgt || link.link_data !== m_ld) begin
            failures++; $display("FAIL rand_data cyc %0d got tgt=%h data=%h want %h %h", n, pc_target_o, link.link_data, m_tgt, m_ld);
         end
         checks++;
         if (taken_cnt_o !== (STATS ? 16'(m_taken) : 16'd0) || bl_cnt_o !== (STATS ? 16'(m_bl) : 16'd0) ||
             drop_cnt_o !== (STATS ? 16'(m_drop) : 16'd0)) begin
            failures++; $display("FAIL rand_stats cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d (stats=%0d)", n,
               taken_cnt_o, bl_cnt_o, drop_cnt_o, m_taken, m_bl, m_drop, STATS);
         end
      end
   endtask

   initial begin
      reset = 1; link.link_ready = 0;
      drive(0, 0, 0, 0);
      model_reset();
      test_reset();
      test_plain_b();
      test_bl_ready();
      test_bl_wait();
      test_drop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
